// File: rtl/muldiv_iter.sv
// Iterative radix-2 multiply / restoring divide unit for the EX stage.
// One bit per cycle; the result register holds until the next completed operation.
module muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               start,
  input  logic               is_div,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               busy,
  output logic               ready,
  output logic               div_zero,
  output logic [2*WIDTH-1:0] result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               op_div_q, op_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               ready_q, ready_d;
  logic               div_zero_q, div_zero_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0]   x_mag, y_mag;
  logic [WIDTH:0]     sum, shifted, diff;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
  logic [WIDTH-1:0]   rem_next, quo_raw, quo_fix, rem_fix;

  always_comb begin
    x_mag    = (is_signed && x[WIDTH-1]) ? -x : x;
    y_mag    = (is_signed && y[WIDTH-1]) ? -y : y;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
    mul_next = acc_q[0] ? {sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};

    // Divide: quotient bits shift into acc low half as dividend bits shift out.
    shifted  = {rem_q, acc_q[WIDTH-1]};
    diff     = shifted - {1'b0, opb_q};
    rem_next = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    div_next = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~diff[WIDTH]};

    prod_fix = neg_res_q ? -acc_q : acc_q;
    quo_raw  = acc_q[WIDTH-1:0];
    quo_fix  = neg_res_q ? -quo_raw : quo_raw;
    rem_fix  = neg_rem_q ? -rem_q : rem_q;

    state_d    = state_q;
    cnt_d      = cnt_q;
    op_div_d   = op_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    dz_d       = dz_q;
    opb_d      = opb_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    ready_d    = 1'b0;
    div_zero_d = div_zero_q;
    result_d   = result_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CALC;
          cnt_d     = '0;
          rem_d     = '0;
          op_div_d  = is_div;
          neg_res_d = is_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
          neg_rem_d = is_signed & x[WIDTH-1];
          if (is_div && (y == '0)) begin
            dz_d  = 1'b1;
            opb_d = '0;
            acc_d = {{WIDTH{1'b0}}, x};
          end else begin
            dz_d  = 1'b0;
            opb_d = is_div ? y_mag : x_mag;
            acc_d = {{WIDTH{1'b0}}, (is_div ? x_mag : y_mag)};
          end
        end
      end
      S_CALC: begin
        if (dz_q) begin
          // Divide by zero skips iteration: raw dividend high, all-ones low.
          result_d   = {acc_q[WIDTH-1:0], {WIDTH{1'b1}}};
          div_zero_d = 1'b1;
          ready_d    = 1'b1;
          state_d    = S_DONE;
        end else if (cnt_q == LAST_CNT) begin
          result_d   = op_div_q ? {rem_fix, quo_fix} : prod_fix;
          div_zero_d = 1'b0;
          ready_d    = 1'b1;
          state_d    = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (op_div_q) begin
            acc_d = div_next;
            rem_d = rem_next;
          end else begin
            acc_d = mul_next;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Flush abandons any operation without touching the visible result.
    if (flush) begin
      state_d    = S_IDLE;
      ready_d    = 1'b0;
      result_d   = result_q;
      div_zero_d = div_zero_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      opb_q      <= '0;
      acc_q      <= '0;
      rem_q      <= '0;
      ready_q    <= 1'b0;
      div_zero_q <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_div_q   <= op_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      dz_q       <= dz_d;
      opb_q      <= opb_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      ready_q    <= ready_d;
      div_zero_q <= div_zero_d;
      result_q   <= result_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign ready    = ready_q;
  assign div_zero = div_zero_q;
  assign result   = result_q;

endmodule
